// File: rtl/ll8_rx_frame_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ll8_rx_frame_buffer                                              |
// | Purpose : Store-and-forward frame buffer for the 8-bit LocalLink RX        |
// |           stream. Frames are written into a circular buffer and only       |
// |           become visible to the read side once their eof arrives without   |
// |           error. Errored, overrun or truncated frames are rewound.         |
// | Ports   : clk, reset_n (async, active-low), clear (sync flush)             |
// |           in_*  : LocalLink input  (data, sof, eof, error, src/dst rdy)    |
// |           out_* : LocalLink output (data, sof, eof, src/dst rdy)           |
// |           frames_ok / frames_drop : saturating frame statistics            |
// | Option  : LL8_RXBUF_STATS_EN - when defined, frames_ok/frames_drop are     |
// |           live 16-bit counters; otherwise both are tied to zero.           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ll8_rx_frame_buffer #(
  parameter int AWIDTH = 11
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic [7:0]  in_data,
  input  logic        in_sof,
  input  logic        in_eof,
  input  logic        in_error,
  input  logic        in_src_rdy,
  output logic        in_dst_rdy,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_src_rdy,
  input  logic        out_dst_rdy,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_drop
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] PTR_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] wr_ptr, commit_ptr, rd_ptr;
  logic [AWIDTH-1:0] wr_nxt, commit_nxt;
  logic [AWIDTH-1:0] wr_inc, commit_inc, rd_inc;
  logic [AWIDTH-1:0] waddr;
  logic              wr_full, new_full, empty;
  logic              rdy_q, in_xfer;
  logic              we, inc_ok, inc_drop;

  logic [9:0]        mem [0:DEPTH-1];   // {eof, sof, data}
  logic [9:0]        f_q;               // RAM read register
  logic              f_vld;
  logic              fetch, o_load, out_pop;

  assign wr_inc     = wr_ptr + PTR_ONE;
  assign commit_inc = commit_ptr + PTR_ONE;
  assign rd_inc     = rd_ptr + PTR_ONE;
  // Continuing a frame checks room at wr_ptr; starting a new one checks room
  // at commit_ptr because any partial frame is abandoned first.
  assign wr_full    = (wr_inc == rd_ptr);
  assign new_full   = (commit_inc == rd_ptr);
  assign empty      = (rd_ptr == commit_ptr);

  assign in_dst_rdy = rdy_q & ~clear;
  assign in_xfer    = in_src_rdy & in_dst_rdy;

  // Write-side decode
  always_comb begin
    state_nxt  = state;
    wr_nxt     = wr_ptr;
    commit_nxt = commit_ptr;
    we         = 1'b0;
    waddr      = wr_ptr;
    inc_ok     = 1'b0;
    inc_drop   = 1'b0;
    if (in_xfer) begin
      if (state == S_RECV && !in_sof) begin
        if (in_eof && in_error) begin
          wr_nxt    = commit_ptr;
          inc_drop  = 1'b1;
          state_nxt = S_IDLE;
        end else if (wr_full) begin
          wr_nxt    = commit_ptr;
          inc_drop  = 1'b1;
          state_nxt = in_eof ? S_IDLE : S_DROP;
        end else begin
          we     = 1'b1;
          waddr  = wr_ptr;
          wr_nxt = wr_inc;
          if (in_eof) begin
            commit_nxt = wr_inc;
            inc_ok     = 1'b1;
            state_nxt  = S_IDLE;
          end
        end
      end else if (state == S_DROP && !in_sof) begin
        if (in_eof) state_nxt = S_IDLE;
      end else if (in_sof) begin
        // New frame from any state; a frame still open in RECV lost its eof.
        wr_nxt = commit_ptr;
        if (state == S_RECV) inc_drop = 1'b1;
        if (in_eof && in_error) begin
          inc_drop  = 1'b1;
          state_nxt = S_IDLE;
        end else if (new_full) begin
          inc_drop  = 1'b1;
          state_nxt = in_eof ? S_IDLE : S_DROP;
        end else begin
          we     = 1'b1;
          waddr  = commit_ptr;
          wr_nxt = commit_inc;
          if (in_eof) begin
            commit_nxt = commit_inc;
            inc_ok     = 1'b1;
            state_nxt  = S_IDLE;
          end else begin
            state_nxt = S_RECV;
          end
        end
      end
      // IDLE without sof: stray byte, ignored.
    end
  end

  // Read side: RAM register followed by one output register. A fetch is
  // issued whenever committed data exists and the RAM register is free or
  // being drained into the output this cycle.
  assign out_pop = out_src_rdy & out_dst_rdy;
  assign o_load  = f_vld & (~out_src_rdy | out_pop);
  assign fetch   = ~empty & (~f_vld | o_load);

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= {in_eof, in_sof, in_data};
    if (fetch) f_q <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q       <= 1'b0;
      state       <= S_IDLE;
      wr_ptr      <= '0;
      commit_ptr  <= '0;
      rd_ptr      <= '0;
      f_vld       <= 1'b0;
      out_src_rdy <= 1'b0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      out_data    <= 8'h00;
    end else if (clear) begin
      rdy_q       <= 1'b1;
      state       <= S_IDLE;
      wr_ptr      <= '0;
      commit_ptr  <= '0;
      rd_ptr      <= '0;
      f_vld       <= 1'b0;
      out_src_rdy <= 1'b0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      out_data    <= 8'h00;
    end else begin
      rdy_q      <= 1'b1;
      state      <= state_nxt;
      wr_ptr     <= wr_nxt;
      commit_ptr <= commit_nxt;
      if (fetch) begin
        rd_ptr <= rd_inc;
        f_vld  <= 1'b1;
      end else if (o_load) begin
        f_vld  <= 1'b0;
      end
      if (o_load) begin
        out_data    <= f_q[7:0];
        out_sof     <= f_q[8];
        out_eof     <= f_q[9];
        out_src_rdy <= 1'b1;
      end else if (out_pop) begin
        out_src_rdy <= 1'b0;
        out_sof     <= 1'b0;
        out_eof     <= 1'b0;
      end
    end
  end

`ifdef LL8_RXBUF_STATS_EN
  logic [15:0] ok_cnt, drop_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ok_cnt   <= 16'h0000;
      drop_cnt <= 16'h0000;
    end else if (clear) begin
      ok_cnt   <= 16'h0000;
      drop_cnt <= 16'h0000;
    end else begin
      if (inc_ok && ok_cnt != 16'hFFFF) ok_cnt <= ok_cnt + 16'd1;
      if (inc_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign frames_ok   = ok_cnt;
  assign frames_drop = drop_cnt;
`else
  logic unused_stats;
  assign unused_stats = inc_ok | inc_drop;
  assign frames_ok    = 16'h0000;
  assign frames_drop  = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ll8_rx_frame_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module  : tb_ll8_rx_frame_buffer                                           |
// | Purpose : Scoreboard bench for ll8_rx_frame_buffer. Bytes of frames that   |
// |           must emerge are queued as they are sent and popped by an output  |
// |           monitor. Buffer depth is 2**7 (127 usable) so a 64-byte frame    |
// |           fits while a 150-byte frame overflows.                           |
// | Option  : LL8_RXBUF_STATS_EN selects live counter expectations.            |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ll8_rx_frame_buffer;

  localparam int AW = 7;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_sof = 1'b0;
  logic        in_eof = 1'b0;
  logic        in_error = 1'b0;
  logic        in_src_rdy = 1'b0;
  logic        in_dst_rdy;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        out_eof;
  logic        out_src_rdy;
  logic        out_dst_rdy = 1'b1;
  logic [15:0] frames_ok;
  logic [15:0] frames_drop;

  always #5 clk = ~clk;

  ll8_rx_frame_buffer #(.AWIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_data(in_data), .in_sof(in_sof), .in_eof(in_eof), .in_error(in_error),
    .in_src_rdy(in_src_rdy), .in_dst_rdy(in_dst_rdy),
    .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
    .out_src_rdy(out_src_rdy), .out_dst_rdy(out_dst_rdy),
    .frames_ok(frames_ok), .frames_drop(frames_drop)
  );

  int         n_checks = 0;
  int         n_fail = 0;
  int         exp_ok = 0;
  int         exp_drop = 0;
  int         cyc_cnt = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_exp;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [15:0] cnt_exp(input int v);
    logic [15:0] r;
    r = v[15:0];
`ifndef LL8_RXBUF_STATS_EN
    r = 16'h0000;
`endif
    return r;
  endfunction

  // Output monitor: every output transfer must match the head of the queue.
  always @(negedge clk) begin
    if (reset_n && out_src_rdy && out_dst_rdy) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got eof=%b sof=%b data=%h, required no output",
                 out_eof, out_sof, out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({out_eof, out_sof, out_data} !== mon_exp) begin
          n_fail++;
          $display("FAIL out_byte: got {eof,sof,data}=%b_%b_%h, required %b_%b_%h",
                   out_eof, out_sof, out_data, mon_exp[9], mon_exp[8], mon_exp[7:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic s, input logic e, input logic err);
    in_data    = d;
    in_sof     = s;
    in_eof     = e;
    in_error   = err;
    in_src_rdy = 1'b1;
    tick();
    in_src_rdy = 1'b0;
    in_sof     = 1'b0;
    in_eof     = 1'b0;
    in_error   = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [7:0] base, input logic err,
                            input logic expect_out);
    for (int i = 0; i < len; i++) begin
      logic s, e;
      logic [7:0] d;
      s = (i == 0);
      e = (i == len - 1);
      d = base + i[7:0];
      if (expect_out) exp_q.push_back({e, s, d});
      send_byte(d, s, e, err & e);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_src_rdy) && n < 500) begin
      tick();
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0 || out_src_rdy) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d bytes pending, out_src_rdy=%b, required 0 and 0",
               name, exp_q.size(), out_src_rdy);
    end
  endtask

  task automatic check_counts(input string name);
    n_checks++;
    if (frames_ok !== cnt_exp(exp_ok)) begin
      n_fail++;
      $display("FAIL %s_frames_ok: got %0d, required %0d", name, frames_ok, cnt_exp(exp_ok));
    end
    n_checks++;
    if (frames_drop !== cnt_exp(exp_drop)) begin
      n_fail++;
      $display("FAIL %s_frames_drop: got %0d, required %0d", name, frames_drop, cnt_exp(exp_drop));
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({in_dst_rdy, out_src_rdy, out_sof, out_eof, out_data} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got dst=%b src=%b sof=%b eof=%b data=%h, required all 0",
               in_dst_rdy, out_src_rdy, out_sof, out_eof, out_data);
    end
    check_counts("reset");
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (in_dst_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_dst_rdy: got %b, required 1", in_dst_rdy);
    end
  endtask

  task automatic test_good_frame();
    int t_first;
    out_dst_rdy = 1'b1;
    send_frame(64, 8'h10, 1'b0, 1'b1);
    exp_ok++;
    tick();
    n_checks++;
    if (out_src_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_latency_early: got out_src_rdy=%b one clk after eof, required 0", out_src_rdy);
    end
    tick();
    t_first = cyc_cnt;
    n_checks++;
    if ({out_src_rdy, out_sof, out_data} !== {1'b1, 1'b1, 8'h10}) begin
      n_fail++;
      $display("FAIL t1_latency_first: got src=%b sof=%b data=%h two clk after eof, required 1 1 10",
               out_src_rdy, out_sof, out_data);
    end
    wait_drain("t1");
    n_checks++;
    if (cyc_cnt - t_first !== 64) begin
      n_fail++;
      $display("FAIL t1_throughput: got %0d clks for 64 bytes, required 64", cyc_cnt - t_first);
    end
    check_counts("t1");
  endtask

  task automatic test_error_frame();
    send_frame(20, 8'h40, 1'b1, 1'b0);
    exp_drop++;
    send_frame(10, 8'h80, 1'b0, 1'b1);
    exp_ok++;
    wait_drain("t2");
    check_counts("t2");
  endtask

  task automatic test_overflow();
    out_dst_rdy = 1'b0;
    send_frame(150, 8'h00, 1'b0, 1'b0);
    exp_drop++;
    repeat (5) tick();
    n_checks++;
    if (out_src_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_nothing_out: got out_src_rdy=%b, required 0", out_src_rdy);
    end
    send_frame(8, 8'hA0, 1'b0, 1'b1);
    exp_ok++;
    repeat (4) tick();
    n_checks++;
    if ({out_src_rdy, out_sof, out_data} !== {1'b1, 1'b1, 8'hA0}) begin
      n_fail++;
      $display("FAIL t3_head: got src=%b sof=%b data=%h, required 1 1 a0", out_src_rdy, out_sof, out_data);
    end
    repeat (3) tick();
    n_checks++;
    if ({out_src_rdy, out_sof, out_data} !== {1'b1, 1'b1, 8'hA0}) begin
      n_fail++;
      $display("FAIL t3_hold: got src=%b sof=%b data=%h, required 1 1 a0", out_src_rdy, out_sof, out_data);
    end
    out_dst_rdy = 1'b1;
    wait_drain("t3");
    check_counts("t3");
  endtask

  task automatic test_missing_eof();
    for (int i = 0; i < 13; i++) begin
      logic s, e;
      logic [7:0] d;
      s = (i == 0) || (i == 5);
      e = (i == 12);
      d = 8'hC0 + i[7:0];
      if (i >= 5) exp_q.push_back({e, s, d});
      send_byte(d, s, e, 1'b0);
    end
    exp_drop++;
    exp_ok++;
    wait_drain("t4");
    check_counts("t4");
  endtask

  task automatic test_back_to_back();
    out_dst_rdy = 1'b1;
    fork
      begin
        repeat (14) begin
          tick();
          out_dst_rdy = ~out_dst_rdy;
        end
      end
      begin
        exp_q.push_back({1'b1, 1'b1, 8'h11});
        send_byte(8'h11, 1'b1, 1'b1, 1'b0);
        exp_q.push_back({1'b1, 1'b1, 8'h22});
        send_byte(8'h22, 1'b1, 1'b1, 1'b0);
        exp_q.push_back({1'b1, 1'b1, 8'h33});
        send_byte(8'h33, 1'b1, 1'b1, 1'b0);
      end
    join
    exp_ok += 3;
    out_dst_rdy = 1'b1;
    wait_drain("t5");
    check_counts("t5");
  endtask

  task automatic test_clear();
    out_dst_rdy = 1'b0;
    send_frame(6, 8'h50, 1'b0, 1'b0);
    repeat (4) tick();
    clear = 1'b1;
    #1;
    n_checks++;
    if (in_dst_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_dst_rdy: got %b during clear, required 0", in_dst_rdy);
    end
    tick();
    clear = 1'b0;
    exp_ok = 0;
    exp_drop = 0;
    n_checks++;
    if (out_src_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_flush: got out_src_rdy=%b, required 0", out_src_rdy);
    end
    check_counts("clr");
    out_dst_rdy = 1'b1;
    send_frame(4, 8'h60, 1'b0, 1'b1);
    exp_ok++;
    wait_drain("clr");
    check_counts("clr_after");
  endtask

  task automatic test_reset_mid_frame();
    out_dst_rdy = 1'b0;
    send_frame(10, 8'h70, 1'b0, 1'b0);
    exp_ok++;
    send_byte(8'hE0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 5; i++) send_byte(8'hE0 + i[7:0], 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (out_src_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL t6_stored: got out_src_rdy=%b before reset, required 1", out_src_rdy);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({in_dst_rdy, out_src_rdy, out_sof, out_eof, out_data} !== 12'h000) begin
      n_fail++;
      $display("FAIL t6_async_reset: got dst=%b src=%b sof=%b eof=%b data=%h, required all 0",
               in_dst_rdy, out_src_rdy, out_sof, out_eof, out_data);
    end
    exp_ok = 0;
    exp_drop = 0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check_counts("t6_post_reset");
    out_dst_rdy = 1'b1;
    send_frame(12, 8'h90, 1'b0, 1'b1);
    exp_ok++;
    wait_drain("t6");
    check_counts("t6");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_error_frame();
    test_overflow();
    test_missing_eof();
    test_back_to_back();
    test_clear();
    test_reset_mid_frame();
    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
